axi4_mem_slave: RTL
===================

AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 8192, memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter MEM_WORDS_W, default 13, log2(MEM_WORDS).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have AW ports: axi_awvalid_i in 1, axi_awaddr_i in 32, axi_awid_i in 4, axi_awlen_i in 8, axi_awburst_i in 2, axi_awready_o out 1.
REQ-006 SHALL have W ports: axi_wvalid_i in 1, axi_wdata_i in 32, axi_wstrb_i in 4, axi_wlast_i in 1, axi_wready_o out 1.
REQ-007 SHALL have B ports: axi_bvalid_o out 1, axi_bresp_o out 2, axi_bid_o out 4, axi_bready_i in 1.
REQ-008 SHALL have AR ports: axi_arvalid_i in 1, axi_araddr_i in 32, axi_arid_i in 4, axi_arlen_i in 8, axi_arburst_i in 2, axi_arready_o out 1.
REQ-009 SHALL have R ports: axi_rvalid_o out 1, axi_rdata_o out 32, axi_rresp_o out 2, axi_rid_o out 4, axi_rlast_o out 1, axi_rready_i in 1.

Function
REQ-010 SHALL implement FSM states IDLE, WRITE, WRESP, READ; one transaction in flight at a time.
REQ-011 SHALL drive axi_awready_o/axi_arready_o only in IDLE; the other three states hold both low.
REQ-012 SHALL, in IDLE with both awvalid and arvalid high, grant round-robin via 1-bit priority flag: write wins first after reset; flag toggles after each grant.
REQ-013 SHALL, in IDLE with only one valid, grant that channel immediately (ready high combinationally in IDLE, handshake same cycle).
REQ-014 SHALL on grant latch id, len, burst, address; beat counter cleared; error flag cleared.
REQ-015 SHALL word-index memory by addr[MEM_WORDS_W+1:2]; addr[1:0] and bits above ignored (aliasing, no error).
REQ-016 SHALL advance address per beat: FIXED (2'b00) unchanged; INCR (2'b01) +4; WRAP (2'b10) +4 wrapping within aligned block of (len+1)*4 bytes.
REQ-017 SHALL treat burst 2'b11, or WRAP with len not in {1,3,7,15}, as INCR and set the error flag.
REQ-018 SHALL in WRITE hold axi_wready_o high; per W handshake write each byte lane i where wstrb[i]=1, advance address and counter.
REQ-019 SHALL end WRITE on handshake where counter==len, moving to WRESP next cycle; wlast is not used to terminate.
REQ-020 SHALL set the error flag on any W beat where wlast != (counter==len).
REQ-021 SHALL in WRESP drive bvalid=1, bid=latched id, bresp=2'b10 if error flag else 2'b00; hold stable until bready; then IDLE.
REQ-022 SHALL in READ drive rvalid=1, rdata=mem[current index] (asynchronous array read), rid=latched id, rlast=(counter==len), rresp=2'b10 if error flag else 2'b00.
REQ-023 SHALL advance read address/counter on each rvalid&rready; rready low holds all R outputs stable; handshake with rlast=1 returns to IDLE.
REQ-024 SHALL sustain one beat per cycle on W and R; first rvalid in cycle after AR handshake; bvalid in cycle after last W handshake.
REQ-025 SHALL support len 0..255 (1..256 beats); counter 8 bits, no overflow.
REQ-026 SHALL keep memory contents unaffected by reset; uninitialised reads return X in simulation.

Reset
REQ-027 SHALL on rst_ni low immediately force IDLE, counters/flags 0, priority flag to write, all valid/ready/resp/id/last outputs 0.
REQ-028 SHALL abandon any in-progress burst on reset mid-operation; already-written beats stay in memory; no B/R response issued afterwards.

Verification
REQ-029 Write INCR addr 0x80000010 len 3 data 0x11..0x44 wstrb 0xF, bready=1 -> bvalid one cycle after 4th beat, bresp 00, bid echoes; read back same burst -> 0x11,0x22,0x33,0x44, rlast on 4th.
REQ-030 WRAP read addr 0x8000001C len 3 -> word order 0x1C,0x10,0x14,0x18.
REQ-031 Byte write wstrb 0x2 data 0xAABBCCDD to word holding 0x00000000 -> readback 0x0000CC00.
REQ-032 Same-cycle awvalid and arvalid after reset -> AW granted first; next simultaneous request -> AR granted.
REQ-033 Write len 1 with wlast on beat 0 -> two beats still accepted, bresp 2'b10; burst 2'b11 read -> INCR order, rresp 2'b10 all beats.
REQ-034 rst_ni low during beat 2 of 8-beat read with rready toggling -> all outputs 0 same cycle, IDLE, arready high after release.

Source files
------------

// File: rtl/axi4_mem_slave.sv
// Single-outstanding AXI4 memory slave: one FSM serialises write and read bursts
// into a word-addressed array with byte-lane strobes.
module axi4_mem_slave #(
    parameter int MEM_WORDS   = 8192,
    parameter int MEM_WORDS_W = 13
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        axi_awvalid_i,
    input  logic [31:0] axi_awaddr_i,
    input  logic [3:0]  axi_awid_i,
    input  logic [7:0]  axi_awlen_i,
    input  logic [1:0]  axi_awburst_i,
    output logic        axi_awready_o,
    input  logic        axi_wvalid_i,
    input  logic [31:0] axi_wdata_i,
    input  logic [3:0]  axi_wstrb_i,
    input  logic        axi_wlast_i,
    output logic        axi_wready_o,
    output logic        axi_bvalid_o,
    output logic [1:0]  axi_bresp_o,
    output logic [3:0]  axi_bid_o,
    input  logic        axi_bready_i,
    input  logic        axi_arvalid_i,
    input  logic [31:0] axi_araddr_i,
    input  logic [3:0]  axi_arid_i,
    input  logic [7:0]  axi_arlen_i,
    input  logic [1:0]  axi_arburst_i,
    output logic        axi_arready_o,
    output logic        axi_rvalid_o,
    output logic [31:0] axi_rdata_o,
    output logic [1:0]  axi_rresp_o,
    output logic [3:0]  axi_rid_o,
    output logic        axi_rlast_o,
    input  logic        axi_rready_i
);

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [7:0]  cnt;
    logic [1:0]  burst;
    logic        err;
    logic        prio_wr;

    logic [31:0] mem [MEM_WORDS];

    logic                   is_idle;
    logic                   grant_aw;
    logic                   grant_ar;
    logic                   w_hs;
    logic                   r_hs;
    logic                   last;
    logic [MEM_WORDS_W-1:0] idx;
    logic [31:0]            wrap_mask;
    logic [31:0]            next_addr;
    logic [1:0]             req_burst;
    logic [7:0]             req_len;
    logic                   req_bad;

    // Readies are gated by reset so every handshake output reads 0 while rst_ni is low.
    assign is_idle       = (state == IDLE) && rst_ni;
    assign axi_awready_o = is_idle && (prio_wr || !axi_arvalid_i);
    assign axi_arready_o = is_idle && (!prio_wr || !axi_awvalid_i);
    assign grant_aw      = axi_awvalid_i && axi_awready_o;
    assign grant_ar      = axi_arvalid_i && axi_arready_o && !grant_aw;

    assign w_hs = (state == WRITE) && axi_wvalid_i;
    assign r_hs = (state == READ) && axi_rready_i;
    assign last = (cnt == len);
    assign idx  = addr[MEM_WORDS_W+1:2];

    assign req_burst = grant_aw ? axi_awburst_i : axi_arburst_i;
    assign req_len   = grant_aw ? axi_awlen_i : axi_arlen_i;
    // Reserved burst type, or WRAP of an illegal length, degrades to INCR with SLVERR.
    assign req_bad   = (req_burst == 2'b11) ||
                       ((req_burst == 2'b10) && !(req_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_comb begin
        wrap_mask = ((({24'd0, len}) + 32'd1) << 2) - 32'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
            default: next_addr = addr + 32'd4;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            addr    <= '0;
            id      <= '0;
            len     <= '0;
            cnt     <= '0;
            burst   <= '0;
            err     <= 1'b0;
            prio_wr <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_aw || grant_ar) begin
                        addr    <= grant_aw ? axi_awaddr_i : axi_araddr_i;
                        id      <= grant_aw ? axi_awid_i : axi_arid_i;
                        len     <= req_len;
                        burst   <= req_bad ? 2'b01 : req_burst;
                        err     <= req_bad;
                        cnt     <= '0;
                        prio_wr <= !prio_wr;
                        state   <= grant_aw ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (w_hs) begin
                        if (axi_wlast_i != last) err <= 1'b1;
                        addr <= next_addr;
                        cnt  <= cnt + 8'd1;
                        if (last) state <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi_bready_i) state <= IDLE;
                end
                READ: begin
                    if (r_hs) begin
                        addr <= next_addr;
                        cnt  <= cnt + 8'd1;
                        if (last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (axi_wstrb_i[i]) mem[idx][8*i +: 8] <= axi_wdata_i[8*i +: 8];
            end
        end
    end

    assign axi_wready_o = (state == WRITE);
    assign axi_bvalid_o = (state == WRESP);
    assign axi_bresp_o  = (axi_bvalid_o && err) ? 2'b10 : 2'b00;
    assign axi_bid_o    = axi_bvalid_o ? id : 4'd0;
    assign axi_rvalid_o = (state == READ);
    assign axi_rdata_o  = axi_rvalid_o ? mem[idx] : 32'd0;
    assign axi_rresp_o  = (axi_rvalid_o && err) ? 2'b10 : 2'b00;
    assign axi_rid_o    = axi_rvalid_o ? id : 4'd0;
    assign axi_rlast_o  = axi_rvalid_o && last;

endmodule
